// File: rtl/aes_pkg.sv
// Shared AES types and helpers used by the key scheduler and the round datapath.
package aes_pkg;

    typedef logic [7:0]           byte_t;
    typedef logic [31:0]          word_t;
    typedef logic [3:0][3:0][7:0] state_t;

    localparam int NR_AES128 = 10;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } ks_state_e;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Flattened form is {w0,w1,w2,w3}; word c is column c with row 0 as its MSB byte.
    function automatic logic [127:0] state_to_flat(input state_t s);
        logic [127:0] f;
        f = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                f[127 - 32*c - 8*r -: 8] = s[r][c];
            end
        end
        return f;
    endfunction

    function automatic state_t flat_to_state(input logic [127:0] f);
        state_t s;
        s = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                s[r][c] = f[127 - 32*c - 8*r -: 8];
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box for one byte.
module aes_sbox
    import aes_pkg::*;
(
    input  byte_t in,
    output byte_t out
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out = SBOX[in];

endmodule

// File: rtl/inv_key_scheduler.sv
// Expands an AES-128 key one round key per cycle, then serves the keys in reverse order.
module inv_key_scheduler
    import aes_pkg::*;
#(
    parameter int NR   = NR_AES128,
    parameter int RK_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  state_t          key_in,
    input  logic            key_req,
    output logic            ready,
    output logic            busy,
    output state_t          key_out,
    output logic            key_valid,
    output logic [RK_W-1:0] key_idx,
    output logic            key_last
);

    ks_state_e       state, stateNext;
    logic [127:0]    keyMem [0:NR];
    logic [127:0]    lastKey;
    logic [127:0]    nextKey;
    logic [RK_W-1:0] count;
    logic [RK_W-1:0] ptr;
    byte_t           rcon;
    word_t           rotW, subW, tW, n0, n1, n2, n3;
    logic            startAccept;

    assign startAccept = start && (state != EXPAND);

    assign rotW = rot_word(lastKey[31:0]);

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .in  (rotW[8*b +: 8]),
            .out (subW[8*b +: 8])
        );
    end

    assign tW      = subW ^ {rcon, 24'h000000};
    assign n0      = lastKey[127:96] ^ tW;
    assign n1      = lastKey[95:64]  ^ n0;
    assign n2      = lastKey[63:32]  ^ n1;
    assign n3      = lastKey[31:0]   ^ n2;
    assign nextKey = {n0, n1, n2, n3};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = EXPAND;
            EXPAND:  if (count == RK_W'(NR)) stateNext = READY;
            READY:   if (start) stateNext = EXPAND;
            default: stateNext = IDLE;
        endcase
    end

    // Storage is deliberately not reset; ready guards every read of it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (startAccept) begin
                keyMem[0] <= state_to_flat(key_in);
                lastKey   <= state_to_flat(key_in);
            end else if (state == EXPAND) begin
                keyMem[count] <= nextKey;
                lastKey       <= nextKey;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready     <= 1'b0;
            busy      <= 1'b0;
            key_valid <= 1'b0;
            key_last  <= 1'b0;
            key_out   <= '0;
            key_idx   <= '0;
            ptr       <= RK_W'(NR);
            rcon      <= 8'h01;
            count     <= '0;
        end else begin
            key_valid <= 1'b0;
            key_last  <= 1'b0;
            if (startAccept) begin
                rcon  <= 8'h01;
                count <= RK_W'(1);
                busy  <= 1'b1;
                ready <= 1'b0;
            end else if (state == EXPAND) begin
                rcon  <= xtime(rcon);
                count <= count + 1'b1;
                if (count == RK_W'(NR)) begin
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    ptr   <= RK_W'(NR);
                end
            end else if (state == READY && key_req) begin
                key_out   <= flat_to_state(keyMem[ptr]);
                key_idx   <= ptr;
                key_valid <= 1'b1;
                key_last  <= (ptr == '0);
                ptr       <= (ptr == '0) ? RK_W'(NR) : ptr - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inv_key_scheduler.sv
// Scoreboard bench for inv_key_scheduler using FIPS-197 and all-zero key schedules.
module tb_inv_key_scheduler;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [3:0][3:0][7:0] key_in;
    logic                 key_req;
    logic                 ready;
    logic                 busy;
    logic [3:0][3:0][7:0] key_out;
    logic                 key_valid;
    logic [3:0]           key_idx;
    logic                 key_last;

    typedef struct {
        logic [127:0] key;
        int           idx;
        bit           chk;
    } exp_t;

    exp_t         sbQ[$];
    int           total = 0;
    int           bad = 0;
    int           ptrModel = 10;
    logic [127:0] expRk [0:10];
    bit           expChk [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    inv_key_scheduler #(.NR(10), .RK_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .key_req   (key_req),
        .ready     (ready),
        .busy      (busy),
        .key_out   (key_out),
        .key_valid (key_valid),
        .key_idx   (key_idx),
        .key_last  (key_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0][3:0][7:0] toArr(input logic [127:0] w);
        logic [3:0][3:0][7:0] a;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                a[r][c] = w[127 - 32*c - 8*r -: 8];
        return a;
    endfunction

    function automatic logic [127:0] fromArr(input logic [3:0][3:0][7:0] a);
        logic [127:0] w;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                w[127 - 32*c - 8*r -: 8] = a[r][c];
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic [127:0] k);
        @(negedge clk);
        start   = s;
        key_req = r;
        key_in  = toArr(k);
    endtask

    // Monitor side of the scoreboard: every key_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (key_valid) begin
            if (sbQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_valid: got idx %0d expected no key", key_idx);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                if (e.chk) checkOutput("key_out", fromArr(key_out), e.key);
                checkOutput("key_idx", 128'(key_idx), 128'(e.idx));
                checkOutput("key_last", 128'(key_last), 128'(e.idx == 0));
            end
        end
    end

    task automatic expandAndCheck(input logic [127:0] k, input bit reqWithStart,
                                  input int reqAt, input int startAt);
        applyStimulus(1'b1, reqWithStart, k);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(i == startAt, i == reqAt, (i == startAt) ? 128'h0 : k);
            checkOutput("busy_expand", 128'(busy), 128'd1);
            checkOutput("ready_expand", 128'(ready), 128'd0);
        end
        applyStimulus(1'b0, 1'b0, k);
        checkOutput("busy_done", 128'(busy), 128'd0);
        checkOutput("ready_done", 128'(ready), 128'd1);
        ptrModel = 10;
    endtask

    task automatic readSchedule(input int n);
        for (int j = 0; j < n; j++) begin
            exp_t e;
            e.key = expRk[ptrModel];
            e.idx = ptrModel;
            e.chk = expChk[ptrModel];
            sbQ.push_back(e);
            applyStimulus(1'b0, 1'b1, fromArr(key_in));
            ptrModel = (ptrModel == 0) ? 10 : ptrModel - 1;
        end
        applyStimulus(1'b0, 1'b0, fromArr(key_in));
        @(negedge clk);
    endtask

    task automatic loadFips();
        expRk[0]  = FIPS_KEY;
        expRk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        expRk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        expRk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        expRk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        expRk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        expRk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        expRk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        expRk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        expRk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        expRk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i <= 10; i++) expChk[i] = 1'b1;
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        key_req = 1'b0;
        key_in  = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 128'(ready), 128'd0);
        checkOutput("rst_busy", 128'(busy), 128'd0);
        checkOutput("rst_valid", 128'(key_valid), 128'd0);
        checkOutput("rst_key_out", fromArr(key_out), 128'h0);
        checkOutput("rst_key_idx", 128'(key_idx), 128'd0);
        checkOutput("rst_key_last", 128'(key_last), 128'd0);
        rst = 1'b0;

        loadFips();
        expandAndCheck(FIPS_KEY, 1'b0, -1, -1);
        readSchedule(11);
        readSchedule(1);

        // Requests and a stray start during expansion must be ignored.
        expandAndCheck(FIPS_KEY, 1'b0, 2, 4);
        readSchedule(1);

        // Reset in the middle of expansion, then expand the all-zero key.
        applyStimulus(1'b1, 1'b0, FIPS_KEY);
        repeat (5) applyStimulus(1'b0, 1'b0, FIPS_KEY);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, FIPS_KEY);
        rst = 1'b0;
        checkOutput("midrst_ready", 128'(ready), 128'd0);
        checkOutput("midrst_busy", 128'(busy), 128'd0);
        for (int i = 0; i <= 10; i++) expChk[i] = 1'b0;
        expRk[0]  = 128'h0;
        expRk[1]  = 128'h62636363626363636263636362636363;
        expRk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        expChk[0] = 1'b1;
        expChk[1] = 1'b1;
        expChk[10] = 1'b1;
        expandAndCheck(128'h0, 1'b0, -1, -1);
        readSchedule(11);

        // start and key_req together in READY: restart wins, no key delivered.
        loadFips();
        expandAndCheck(FIPS_KEY, 1'b1, -1, -1);
        readSchedule(2);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 128'(sbQ.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
